// File: rtl/seg7_pkg.sv
// Shared definitions for the BCD scan display: digit geometry, segment
// patterns (active-high, bit order {g,f,e,d,c,b,a}) and the scan FSM state.
package seg7_pkg;

    localparam int NUM_DIGITS  = 6;
    localparam int DIGIT_W     = 4;
    localparam int TOP_DIGIT_W = 5;
    localparam int BCD_W       = (NUM_DIGITS - 1) * DIGIT_W + TOP_DIGIT_W;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // ST_LOAD: first cycle out of reset, takes the initial snapshot.
    // ST_SCAN: free-running digit multiplexing.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Extract digit i from the packed word, zero-extended to the top-field width.
    function automatic logic [TOP_DIGIT_W-1:0] digit_field(
        input logic [BCD_W-1:0] bcd,
        input logic [2:0]       i
    );
        logic [TOP_DIGIT_W-1:0] f;
        case (i)
            3'd0:    f = {1'b0, bcd[0*DIGIT_W +: DIGIT_W]};
            3'd1:    f = {1'b0, bcd[1*DIGIT_W +: DIGIT_W]};
            3'd2:    f = {1'b0, bcd[2*DIGIT_W +: DIGIT_W]};
            3'd3:    f = {1'b0, bcd[3*DIGIT_W +: DIGIT_W]};
            3'd4:    f = {1'b0, bcd[4*DIGIT_W +: DIGIT_W]};
            3'd5:    f = bcd[BCD_W-1 -: TOP_DIGIT_W];
            default: f = {TOP_DIGIT_W{1'b0}};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational digit decoder: 0..9 map to their glyphs, anything above 9
// (hex nibbles A-F or the wide top field) shows a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [TOP_DIGIT_W-1:0] value,
    output logic [6:0]             pattern
);

    // Value to active-high segment pattern lookup.
    always_comb begin
        pattern = SEG_DASH;
        case (value)
            5'd0:    pattern = SEG_0;
            5'd1:    pattern = SEG_1;
            5'd2:    pattern = SEG_2;
            5'd3:    pattern = SEG_3;
            5'd4:    pattern = SEG_4;
            5'd5:    pattern = SEG_5;
            5'd6:    pattern = SEG_6;
            5'd7:    pattern = SEG_7;
            5'd8:    pattern = SEG_8;
            5'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed 7-segment driver. Snapshots a packed BCD frame once
// per scan so the displayed digits never tear, applies a dead time at the
// start of every digit dwell, and blanks leading zeros.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic              Sys_CLK,
    input  logic              Sys_RST,
    input  logic [BCD_W-1:0]  Data_BCD,
    input  logic [5:0]        Dp_En,
    output logic [7:0]        Seg,
    output logic [5:0]        Dig_Sel,
    output logic              Frame_Start
);

    localparam int              PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]   PRE_DEAD = PW'(DEAD_CYCLES);
    localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]      SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [5:0]      DIG_OFF  = (DIG_ACT_LOW != 0) ? 6'h3F : 6'h00;

    scan_state_t              state;
    scan_state_t              state_next;
    logic [PW-1:0]            pre;
    logic [PW-1:0]            pre_next;
    logic [2:0]               idx;
    logic [2:0]               idx_next;
    logic [BCD_W-1:0]         snap_bcd;
    logic [5:0]               snap_dp;
    logic                     load;
    logic                     wrap;
    logic [5:0]               blank;
    logic                     any_nz;
    logic [TOP_DIGIT_W-1:0]   field;
    logic [6:0]               pat7;
    logic [7:0]               seg_pat;
    logic [5:0]               dig_on;
    logic [7:0]               seg_next;
    logic [5:0]               dig_next;

    // Field for the digit currently being scanned.
    always_comb begin
        field = digit_field(snap_bcd, idx);
    end

    bcd_to_seg7 u_dec (
        .value   (field),
        .pattern (pat7)
    );

    // Leading-zero mask: a digit is blanked when it and every higher digit
    // are zero with no decimal point requested. Digit 0 always shows.
    always_comb begin
        blank  = 6'b000000;
        any_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            any_nz   = any_nz | (digit_field(snap_bcd, 3'(i)) != {TOP_DIGIT_W{1'b0}}) | snap_dp[i];
            blank[i] = (BLANK_LZ != 0) && (i != 0) && !any_nz;
        end
    end

    // FSM state register.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: one load cycle after reset, then scan forever.
    always_comb begin
        state_next = ST_LOAD;
        case (state)
            ST_LOAD: state_next = ST_SCAN;
            ST_SCAN: state_next = ST_SCAN;
            default: state_next = ST_LOAD;
        endcase
    end

    // FSM outputs: prescaler/index stepping, snapshot strobe and pin values.
    always_comb begin
        wrap     = (pre == PRE_MAX);
        seg_pat  = {snap_dp[idx], pat7};
        dig_on   = 6'b000001 << idx;
        load     = 1'b0;
        pre_next = pre;
        idx_next = idx;
        seg_next = SEG_OFF;
        dig_next = DIG_OFF;
        case (state)
            ST_LOAD: begin
                load     = 1'b1;
                pre_next = {PW{1'b0}};
                idx_next = 3'd0;
            end
            ST_SCAN: begin
                load = wrap && (idx == IDX_LAST);
                if (wrap) begin
                    pre_next = {PW{1'b0}};
                    idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                end else begin
                    pre_next = pre + PW'(1);
                    idx_next = idx;
                end
                if (blank[idx]) begin
                    seg_next = SEG_OFF;
                end else if (SEG_ACT_LOW != 0) begin
                    seg_next = ~seg_pat;
                end else begin
                    seg_next = seg_pat;
                end
                if ((pre >= PRE_DEAD) && !blank[idx]) begin
                    dig_next = (DIG_ACT_LOW != 0) ? ~dig_on : dig_on;
                end else begin
                    dig_next = DIG_OFF;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // Datapath and registered pins; reset aborts any frame in progress.
    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            pre         <= {PW{1'b0}};
            idx         <= 3'd0;
            snap_bcd    <= {BCD_W{1'b0}};
            snap_dp     <= 6'b000000;
            Frame_Start <= 1'b0;
            Seg         <= SEG_OFF;
            Dig_Sel     <= DIG_OFF;
        end else begin
            pre         <= pre_next;
            idx         <= idx_next;
            if (load) begin
                snap_bcd <= Data_BCD;
                snap_dp  <= Dp_En;
            end
            Frame_Start <= load;
            Seg         <= seg_next;
            Dig_Sel     <= dig_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with CLK_DIV=8, DEAD_CYCLES=2,
// active-low segments and digits, leading-zero blanking enabled.
// Timing reference: F is the cycle where Frame_Start is high. Capture index
// c (0..47) is cycle F+1+c; slot k = c/8, position p = c%8; p=0,1 are dead.
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] data;
    logic [5:0]  dp;
    logic [7:0]  seg;
    logic [5:0]  dig;
    logic        fs;

    int vectors     = 0;
    int miscompares = 0;

    logic [5:0]  obs_dig [48];
    logic [7:0]  obs_seg [48];
    logic [47:0] obs_fs;

    always #5 clk = ~clk;

    bcd_scan_display #(
        .CLK_DIV     (8),
        .DEAD_CYCLES (2),
        .SEG_ACT_LOW (1),
        .DIG_ACT_LOW (1),
        .BLANK_LZ    (1)
    ) dut (
        .Sys_CLK     (clk),
        .Sys_RST     (rst),
        .Data_BCD    (data),
        .Dp_En       (dp),
        .Seg         (seg),
        .Dig_Sel     (dig),
        .Frame_Start (fs)
    );

    task automatic wait_fs(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (fs === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s: Frame_Start not seen within 200 cycles", name);
        end
    endtask

    task automatic capture_frame();
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            obs_dig[c] = dig;
            obs_seg[c] = seg;
            obs_fs[c]  = fs;
        end
    endtask

    // One frame of given content: exp_segs holds pin values {d5..d0}, act the
    // digits expected to light.
    task automatic test_frame_case(input string name, input logic [24:0] d,
                                   input logic [5:0] dpv, input logic [47:0] exp_segs,
                                   input logic [5:0] act, input bit do_sync);
        logic [5:0] exp_d;
        data = d;
        dp   = dpv;
        if (do_sync) wait_fs(name);
        capture_frame();
        vectors++;
        if (obs_fs !== 48'h8000_0000_0000) begin
            miscompares++;
            $display("FAIL %s frame_start: got %h want 800000000000", name, obs_fs);
        end
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < 8; p++) begin
                exp_d = 6'b111111;
                if (p >= 2 && act[k]) exp_d[k] = 1'b0;
                vectors++;
                if (obs_dig[k*8+p] !== exp_d) begin
                    miscompares++;
                    $display("FAIL %s dig slot%0d p%0d: got %h want %h", name, k, p, obs_dig[k*8+p], exp_d);
                end
                if (p >= 2 && act[k]) begin
                    vectors++;
                    if (obs_seg[k*8+p] !== exp_segs[k*8 +: 8]) begin
                        miscompares++;
                        $display("FAIL %s seg slot%0d p%0d: got %h want %h", name, k, p, obs_seg[k*8+p], exp_segs[k*8 +: 8]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        data = 25'h0123456;
        dp   = 6'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (seg !== 8'hFF) begin miscompares++; $display("FAIL reset_seg: got %h want ff", seg); end
        vectors++;
        if (dig !== 6'h3F) begin miscompares++; $display("FAIL reset_dig: got %h want 3f", dig); end
        vectors++;
        if (fs !== 1'b0) begin miscompares++; $display("FAIL reset_fs: got %b want 0", fs); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (fs !== 1'b1) begin miscompares++; $display("FAIL first_fs: got %b want 1", fs); end
        vectors++;
        if (dig !== 6'h3F) begin miscompares++; $display("FAIL first_dig: got %h want 3f", dig); end
    endtask

    task automatic test_patterns();
        // d0=6 d1=5 d2=4 d3=3 d4=2 d5=1; first frame straight after reset
        test_frame_case("digits",   25'h0123456, 6'h00, 48'hF9_A4_B0_99_92_82, 6'b111111, 1'b0);
        test_frame_case("repeat",   25'h0123456, 6'h00, 48'hF9_A4_B0_99_92_82, 6'b111111, 1'b0);
        test_frame_case("only_d0",  25'h0000007, 6'h00, 48'hFF_FF_FF_FF_FF_F8, 6'b000001, 1'b1);
        test_frame_case("dp_d2",    25'h0000000, 6'h04, 48'hFF_FF_FF_40_C0_C0, 6'b000111, 1'b1);
        test_frame_case("inner_z",  25'h0000305, 6'h00, 48'hFF_FF_FF_B0_C0_92, 6'b000111, 1'b1);
        test_frame_case("dp_d0",    25'h0000012, 6'h01, 48'hFF_FF_FF_FF_F9_24, 6'b000011, 1'b1);
        test_frame_case("dp_d4",    25'h0000000, 6'h10, 48'hFF_40_C0_C0_C0_C0, 6'b011111, 1'b1);
        test_frame_case("dash",     25'h1F0000C, 6'h00, 48'hBF_C0_C0_C0_C0_BF, 6'b111111, 1'b1);
        test_frame_case("d5_ten",   25'h0A00000, 6'h00, 48'hBF_C0_C0_C0_C0_C0, 6'b111111, 1'b1);
    endtask

    task automatic test_no_tearing();
        data = 25'h0111111;
        dp   = 6'h00;
        wait_fs("tear_sync");
        for (int c = 0; c < 48; c++) begin
            if (c == 20) data = 25'h0999999;
            @(negedge clk);
            obs_seg[c] = seg;
            obs_fs[c]  = fs;
        end
        vectors++;
        if (obs_fs !== 48'h8000_0000_0000) begin
            miscompares++;
            $display("FAIL tear_fs: got %h want 800000000000", obs_fs);
        end
        for (int k = 0; k < 6; k++) begin
            for (int p = 2; p < 8; p++) begin
                vectors++;
                if (obs_seg[k*8+p] !== 8'hF9) begin
                    miscompares++;
                    $display("FAIL tear_old slot%0d p%0d: got %h want f9", k, p, obs_seg[k*8+p]);
                end
            end
        end
        test_frame_case("tear_new", 25'h0999999, 6'h00, 48'h90_90_90_90_90_90, 6'b111111, 1'b0);
    endtask

    task automatic test_mid_reset();
        data = 25'h0123456;
        dp   = 6'h00;
        wait_fs("mrst_sync");
        repeat (12) @(negedge clk);
        rst  = 1'b1;
        data = 25'h0000042;
        @(negedge clk);
        vectors++;
        if (seg !== 8'hFF) begin miscompares++; $display("FAIL mrst_seg: got %h want ff", seg); end
        vectors++;
        if (dig !== 6'h3F) begin miscompares++; $display("FAIL mrst_dig: got %h want 3f", dig); end
        vectors++;
        if (fs !== 1'b0) begin miscompares++; $display("FAIL mrst_fs: got %b want 0", fs); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (fs !== 1'b1) begin miscompares++; $display("FAIL mrst_restart_fs: got %b want 1", fs); end
        test_frame_case("mrst_frame", 25'h0000042, 6'h00, 48'hFF_FF_FF_FF_99_A4, 6'b000011, 1'b0);
    endtask

    task automatic test_monitor();
        logic [5:0] exp_d;
        int         p;
        int         k;
        data = 25'h0123456;
        dp   = 6'h00;
        wait_fs("mon_sync");
        for (int c = 0; c < 480; c++) begin
            @(negedge clk);
            p = c % 8;
            k = (c / 8) % 6;
            vectors++;
            if ($countones(~dig) > 1) begin
                miscompares++;
                $display("FAIL mon_onehot cyc%0d: got %h want at most one low bit", c, dig);
            end
            exp_d = 6'b111111;
            if (p >= 2) exp_d[k] = 1'b0;
            vectors++;
            if (dig !== exp_d) begin
                miscompares++;
                $display("FAIL mon_dwell cyc%0d p%0d: got %h want %h", c, p, dig, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_no_tearing();
        test_mid_reset();
        test_monitor();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
